slice_detector_multi: RTL and testbench

// - Two-hand successor to the single-hand slice checker: per block sample, decides slice (either saber),

---
 rtl/slice_detector_multi.sv | 266 ++++++++++++++++++++++++++
 tb/tb_slice_detector_multi.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/slice_detector_multi.sv
// slice_detector_multi
//   Two-hand slice / head-hit / block-miss decision for one block sample per
//   cycle. Two registered stages:
//     S1: swing direction per hand, saber-vs-block and head-vs-obstacle
//         overlap tests; block fields and frame time are carried along.
//     S2: slice/hit/miss decision against per-ID history, per-hand cooldown
//         and last-hit/last-miss IDs; pulses and the sliced-block copy are
//         registered here, so a sample at cycle N yields pulses at N+2.
//   Handshake: blk_valid_in qualifies the block fields for one cycle. There
//   is no ready; every valid sample is consumed (no backpressure).
// Ports
//   clk_in, rst_n_in            clock, asynchronous active-low reset
//   curr_time                   frame timestamp
//   blk_valid_in                block fields valid this cycle
//   block_x/y/z, block_visible, block_color, block_obstacle,
//   block_direction, block_ID   block sample
//   prev_/curr_ l/r _x/_y       saber-top positions, previous and current
//   head_x, head_y              head position
//   slice_out, slice_hand_out   slice pulse, hand (0 left, 1 right)
//   block_*_out                 copy of the last sliced block (held)
//   hit_out, miss_out           head-hit pulse, block-miss pulse
module slice_detector_multi #(
  parameter int MOVE_THRESH = 32,
  parameter int HIT_HALF    = 100,
  parameter int SLICE_Z_MAX = 600,
  parameter int HEAD_HALF   = 150,
  parameter int HEAD_Z_MAX  = 200,
  parameter int HIST_DEPTH  = 4,
  parameter bit COLOR_MATCH = 1'b1
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [17:0] curr_time,
  input  logic        blk_valid_in,
  input  logic [11:0] block_x,
  input  logic [11:0] block_y,
  input  logic [13:0] block_z,
  input  logic        block_visible,
  input  logic        block_color,
  input  logic        block_obstacle,
  input  logic [2:0]  block_direction,
  input  logic [7:0]  block_ID,
  input  logic [11:0] prev_l_x,
  input  logic [11:0] prev_l_y,
  input  logic [11:0] curr_l_x,
  input  logic [11:0] curr_l_y,
  input  logic [11:0] prev_r_x,
  input  logic [11:0] prev_r_y,
  input  logic [11:0] curr_r_x,
  input  logic [11:0] curr_r_y,
  input  logic [11:0] head_x,
  input  logic [11:0] head_y,
  output logic        slice_out,
  output logic        slice_hand_out,
  output logic [11:0] block_x_out,
  output logic [11:0] block_y_out,
  output logic [13:0] block_z_out,
  output logic        block_color_out,
  output logic [2:0]  block_direction_out,
  output logic [7:0]  block_ID_out,
  output logic        hit_out,
  output logic        miss_out
);

  localparam logic [2:0] DIR_UP    = 3'd0;
  localparam logic [2:0] DIR_RIGHT = 3'd1;
  localparam logic [2:0] DIR_DOWN  = 3'd2;
  localparam logic [2:0] DIR_LEFT  = 3'd3;
  localparam logic [2:0] DIR_ANY   = 3'd4;

  localparam int PTR_W = $clog2(HIST_DEPTH);

  localparam logic [12:0] MOVE_T  = 13'(MOVE_THRESH);
  localparam logic [12:0] HIT_T   = 13'(HIT_HALF);
  localparam logic [12:0] HEAD_T  = 13'(HEAD_HALF);
  localparam logic [13:0] SLICE_Z = 14'(SLICE_Z_MAX);
  localparam logic [13:0] HEAD_Z  = 14'(HEAD_Z_MAX);

  // Differences are taken on zero-extended operands in 13-bit signed, so
  // positions near 0 or 4095 never wrap.
  function automatic logic signed [12:0] diff13(input logic [11:0] a,
                                                input logic [11:0] b);
    return $signed({1'b0, a}) - $signed({1'b0, b});
  endfunction

  function automatic logic [12:0] abs13(input logic signed [12:0] d);
    logic [12:0] r;
    r = d[12] ? 13'(-d) : 13'(d);
    return r;
  endfunction

  // Dominant-axis swing direction; equal magnitudes give ANY.
  function automatic logic [2:0] swing_dir(input logic [11:0] px,
                                           input logic [11:0] py,
                                           input logic [11:0] cx,
                                           input logic [11:0] cy);
    logic signed [12:0] dx, dy;
    logic [12:0] ax, ay;
    logic [2:0] d;
    dx = diff13(cx, px);
    dy = diff13(cy, py);
    ax = abs13(dx);
    ay = abs13(dy);
    if (ax >= MOVE_T && ax > ay)      d = dx[12] ? DIR_LEFT : DIR_RIGHT;
    else if (ay >= MOVE_T && ay > ax) d = dy[12] ? DIR_UP : DIR_DOWN;
    else                              d = DIR_ANY;
    return d;
  endfunction

  function automatic logic box_hit(input logic [11:0] ax, input logic [11:0] ay,
                                   input logic [11:0] bx, input logic [11:0] by,
                                   input logic [12:0] half);
    return (abs13(diff13(ax, bx)) <= half) && (abs13(diff13(ay, by)) <= half);
  endfunction

  // ---------------- S1 ----------------
  logic        s1_valid;
  logic [17:0] s1_time;
  logic [11:0] s1_x, s1_y;
  logic [13:0] s1_z;
  logic        s1_visible, s1_color, s1_obstacle;
  logic [2:0]  s1_direction;
  logic [7:0]  s1_id;
  logic [2:0]  s1_dir_l, s1_dir_r;
  logic        s1_ovl_l, s1_ovl_r, s1_head_ovl;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s1_valid     <= 1'b0;
      s1_time      <= '0;
      s1_x         <= '0;
      s1_y         <= '0;
      s1_z         <= '0;
      s1_visible   <= 1'b0;
      s1_color     <= 1'b0;
      s1_obstacle  <= 1'b0;
      s1_direction <= DIR_UP;
      s1_id        <= '0;
      s1_dir_l     <= DIR_ANY;
      s1_dir_r     <= DIR_ANY;
      s1_ovl_l     <= 1'b0;
      s1_ovl_r     <= 1'b0;
      s1_head_ovl  <= 1'b0;
    end else begin
      s1_valid     <= blk_valid_in;
      s1_time      <= curr_time;
      s1_x         <= block_x;
      s1_y         <= block_y;
      s1_z         <= block_z;
      s1_visible   <= block_visible;
      s1_color     <= block_color;
      s1_obstacle  <= block_obstacle;
      s1_direction <= block_direction;
      s1_id        <= block_ID;
      s1_dir_l     <= swing_dir(prev_l_x, prev_l_y, curr_l_x, curr_l_y);
      s1_dir_r     <= swing_dir(prev_r_x, prev_r_y, curr_r_x, curr_r_y);
      s1_ovl_l     <= box_hit(block_x, block_y, curr_l_x, curr_l_y, HIT_T);
      s1_ovl_r     <= box_hit(block_x, block_y, curr_r_x, curr_r_y, HIT_T);
      s1_head_ovl  <= box_hit(block_x, block_y, head_x, head_y, HEAD_T);
    end
  end

  // ---------------- S2 state ----------------
  logic [7:0]            hist_id [HIST_DEPTH];
  logic [HIST_DEPTH-1:0] hist_vld;
  logic [PTR_W-1:0]      hist_wptr;
  logic [17:0]           last_slice_time;
  logic [2:0]            cool_l, cool_r;
  logic [7:0]            last_hit_id, last_miss_id;
  logic                  last_hit_vld, last_miss_vld;

  // The history is written on the same edge that registers slice_out, so
  // the very next sample already sees the new entry: a back-to-back
  // repeat of the same ID is rejected without a separate forwarding path.
  logic in_hist;
  always_comb begin
    in_hist = 1'b0;
    for (int i = 0; i < HIST_DEPTH; i++) begin
      if (hist_vld[i] && hist_id[i] == s1_id) in_hist = 1'b1;
    end
  end

  logic qual_l, qual_r, slice_now, hit_now, miss_now;
  always_comb begin
    qual_l = (s1_dir_l != DIR_ANY) &&
             (s1_direction == DIR_ANY || s1_dir_l == s1_direction) &&
             s1_ovl_l && (cool_l == 3'd0) &&
             (!COLOR_MATCH || s1_color == 1'b0);
    qual_r = (s1_dir_r != DIR_ANY) &&
             (s1_direction == DIR_ANY || s1_dir_r == s1_direction) &&
             s1_ovl_r && (cool_r == 3'd0) &&
             (!COLOR_MATCH || s1_color == 1'b1);
    slice_now = s1_valid && s1_visible && !s1_obstacle && (s1_z <= SLICE_Z) &&
                !in_hist && (s1_time != last_slice_time) && (qual_l || qual_r);
    hit_now   = s1_valid && s1_visible && s1_obstacle && (s1_z <= HEAD_Z) &&
                s1_head_ovl && !(last_hit_vld && last_hit_id == s1_id);
    // A z==0 block that is being sliced right now is not also a miss.
    miss_now  = s1_valid && s1_visible && !s1_obstacle && (s1_z == 14'd0) &&
                !in_hist && !(last_miss_vld && last_miss_id == s1_id) &&
                !slice_now;
  end

  // Left wins when both hands qualify.
  logic slice_hand;
  assign slice_hand = !qual_l;

  always_ff @(posedge clk_in) begin
    if (slice_now) hist_id[hist_wptr] <= s1_id;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hist_vld            <= '0;
      hist_wptr           <= '0;
      last_slice_time     <= '0;
      cool_l              <= '0;
      cool_r              <= '0;
      last_hit_id         <= '0;
      last_hit_vld        <= 1'b0;
      last_miss_id        <= '0;
      last_miss_vld       <= 1'b0;
      slice_out           <= 1'b0;
      slice_hand_out      <= 1'b0;
      block_x_out         <= '0;
      block_y_out         <= '0;
      block_z_out         <= '0;
      block_color_out     <= 1'b0;
      block_direction_out <= '0;
      block_ID_out        <= '0;
      hit_out             <= 1'b0;
      miss_out            <= 1'b0;
    end else begin
      slice_out <= slice_now;
      hit_out   <= hit_now;
      miss_out  <= miss_now;

      if (cool_l != 3'd0) cool_l <= cool_l - 3'd1;
      if (cool_r != 3'd0) cool_r <= cool_r - 3'd1;

      if (slice_now) begin
        hist_vld[hist_wptr] <= 1'b1;
        hist_wptr           <= hist_wptr + 1'b1;
        last_slice_time     <= s1_time;
        slice_hand_out      <= slice_hand;
        block_x_out         <= s1_x;
        block_y_out         <= s1_y;
        block_z_out         <= s1_z;
        block_color_out     <= s1_color;
        block_direction_out <= s1_direction;
        block_ID_out        <= s1_id;
        if (slice_hand) cool_r <= 3'd7;
        else            cool_l <= 3'd7;
      end

      if (hit_now) begin
        last_hit_id  <= s1_id;
        last_hit_vld <= 1'b1;
      end
      if (miss_now) begin
        last_miss_id  <= s1_id;
        last_miss_vld <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_slice_detector_multi.sv
module tb_slice_detector_multi;

  // ---------------- clock / reset ----------------
  logic clk_in = 1'b0;
  logic rst_n_in;
  always #5 clk_in = ~clk_in;

  logic [17:0] curr_time;
  logic        blk_valid_in;
  logic [11:0] block_x, block_y;
  logic [13:0] block_z;
  logic        block_visible, block_color, block_obstacle;
  logic [2:0]  block_direction;
  logic [7:0]  block_ID;
  logic [11:0] prev_l_x, prev_l_y, curr_l_x, curr_l_y;
  logic [11:0] prev_r_x, prev_r_y, curr_r_x, curr_r_y;
  logic [11:0] head_x, head_y;

  logic        slice_out, slice_hand_out, hit_out, miss_out;
  logic [11:0] block_x_out, block_y_out;
  logic [13:0] block_z_out;
  logic        block_color_out;
  logic [2:0]  block_direction_out;
  logic [7:0]  block_ID_out;

  logic        a_slice, a_hand, a_hit, a_miss, a_color;
  logic [11:0] a_x, a_y;
  logic [13:0] a_z;
  logic [2:0]  a_dir;
  logic [7:0]  a_id;

  slice_detector_multi dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .curr_time(curr_time),
    .blk_valid_in(blk_valid_in), .block_x(block_x), .block_y(block_y),
    .block_z(block_z), .block_visible(block_visible), .block_color(block_color),
    .block_obstacle(block_obstacle), .block_direction(block_direction),
    .block_ID(block_ID),
    .prev_l_x(prev_l_x), .prev_l_y(prev_l_y), .curr_l_x(curr_l_x), .curr_l_y(curr_l_y),
    .prev_r_x(prev_r_x), .prev_r_y(prev_r_y), .curr_r_x(curr_r_x), .curr_r_y(curr_r_y),
    .head_x(head_x), .head_y(head_y),
    .slice_out(slice_out), .slice_hand_out(slice_hand_out),
    .block_x_out(block_x_out), .block_y_out(block_y_out), .block_z_out(block_z_out),
    .block_color_out(block_color_out), .block_direction_out(block_direction_out),
    .block_ID_out(block_ID_out), .hit_out(hit_out), .miss_out(miss_out)
  );

  // Same stimulus, either hand may slice either colour.
  slice_detector_multi #(.COLOR_MATCH(1'b0)) dut_any (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .curr_time(curr_time),
    .blk_valid_in(blk_valid_in), .block_x(block_x), .block_y(block_y),
    .block_z(block_z), .block_visible(block_visible), .block_color(block_color),
    .block_obstacle(block_obstacle), .block_direction(block_direction),
    .block_ID(block_ID),
    .prev_l_x(prev_l_x), .prev_l_y(prev_l_y), .curr_l_x(curr_l_x), .curr_l_y(curr_l_y),
    .prev_r_x(prev_r_x), .prev_r_y(prev_r_y), .curr_r_x(curr_r_x), .curr_r_y(curr_r_y),
    .head_x(head_x), .head_y(head_y),
    .slice_out(a_slice), .slice_hand_out(a_hand),
    .block_x_out(a_x), .block_y_out(a_y), .block_z_out(a_z),
    .block_color_out(a_color), .block_direction_out(a_dir),
    .block_ID_out(a_id), .hit_out(a_hit), .miss_out(a_miss)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  int n_slice, n_hit, n_miss, n_slice_any;
  logic last_hand, last_hand_any;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_counts();
    n_slice = 0; n_hit = 0; n_miss = 0; n_slice_any = 0;
    last_hand = 1'b0; last_hand_any = 1'b0;
  endtask

  // One clock; outputs are sampled on the falling edge, then time advances.
  task automatic step();
    @(posedge clk_in);
    @(negedge clk_in);
    if (slice_out) begin n_slice++; last_hand = slice_hand_out; end
    if (hit_out)   n_hit++;
    if (miss_out)  n_miss++;
    if (a_slice) begin n_slice_any++; last_hand_any = a_hand; end
    curr_time = curr_time + 18'd1;
  endtask

  task automatic set_left(input int px, input int py, input int cx, input int cy);
    prev_l_x = 12'(px); prev_l_y = 12'(py); curr_l_x = 12'(cx); curr_l_y = 12'(cy);
  endtask

  task automatic set_right(input int px, input int py, input int cx, input int cy);
    prev_r_x = 12'(px); prev_r_y = 12'(py); curr_r_x = 12'(cx); curr_r_y = 12'(cy);
  endtask

  task automatic set_block(input int x, input int y, input int z, input bit color,
                           input bit obs, input int dir, input int id);
    block_x = 12'(x); block_y = 12'(y); block_z = 14'(z);
    block_visible = 1'b1; block_color = color; block_obstacle = obs;
    block_direction = 3'(dir); block_ID = 8'(id);
  endtask

  task automatic idle_hands();
    set_left(3000, 3000, 3000, 3000);
    set_right(3000, 3000, 3000, 3000);
  endtask

  // Valid for n consecutive cycles, then long enough idle for the pulses
  // to drain and both cooldowns to expire.
  task automatic send(input int n);
    blk_valid_in = 1'b1;
    repeat (n) step();
    blk_valid_in = 1'b0;
    repeat (10) step();
  endtask

  // ---------------- directed tests ----------------
  initial begin
    rst_n_in = 1'b0;
    curr_time = 18'd0;
    blk_valid_in = 1'b0;
    head_x = 12'd2000; head_y = 12'd2000;
    idle_hands();
    set_block(0, 0, 0, 1'b0, 1'b0, 0, 0);
    clear_counts();

    repeat (3) @(negedge clk_in);
    check("rst_slice", slice_out, 0);
    check("rst_hand", slice_hand_out, 0);
    check("rst_hit", hit_out, 0);
    check("rst_miss", miss_out, 0);
    check("rst_id", block_ID_out, 0);
    check("rst_x", block_x_out, 0);
    rst_n_in = 1'b1;
    repeat (2) step();

    // Basic DOWN swing, two-cycle latency, sliced-block copy.
    set_left(500, 300, 500, 340);
    set_block(520, 360, 400, 1'b0, 1'b0, 2, 5);
    blk_valid_in = 1'b1;
    step();
    check("t1_latency", slice_out, 0);
    blk_valid_in = 1'b0;
    step();
    check("t1_slice", slice_out, 1);
    check("t1_hand", slice_hand_out, 0);
    check("t1_id", block_ID_out, 5);
    check("t1_x", block_x_out, 520);
    check("t1_y", block_y_out, 360);
    check("t1_z", block_z_out, 400);
    check("t1_dir", block_direction_out, 2);
    check("t1_color", block_color_out, 0);
    step();
    check("t1_pulse_end", slice_out, 0);
    check("t1_id_held", block_ID_out, 5);
    repeat (8) step();

    // Diagonal |dx|==|dy| swing is ANY and cannot slice a DOWN block.
    clear_counts();
    set_left(500, 300, 540, 340);
    set_block(520, 360, 400, 1'b0, 1'b0, 2, 6);
    send(1);
    check("diag_no_slice", n_slice, 0);

    // ANY block accepts a RIGHT swing.
    clear_counts();
    set_left(500, 340, 540, 340);
    set_block(520, 360, 400, 1'b0, 1'b0, 4, 6);
    send(1);
    check("any_slice", n_slice, 1);
    check("any_dir_out", block_direction_out, 4);
    check("any_id_out", block_ID_out, 6);

    // Reset while a sliceable sample sits in S1: nothing comes out.
    clear_counts();
    set_left(500, 300, 500, 340);
    set_block(520, 360, 400, 1'b0, 1'b0, 2, 20);
    blk_valid_in = 1'b1;
    step();
    blk_valid_in = 1'b0;
    rst_n_in = 1'b0;
    #2;
    check("midrst_slice", slice_out, 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    repeat (10) step();
    check("midrst_no_pulse", n_slice, 0);
    check("midrst_id_clr", block_ID_out, 0);

    // History: ID 5 three cycles -> one slice; repeat blocked until
    // four other IDs have pushed it out.
    clear_counts();
    set_block(520, 360, 400, 1'b0, 1'b0, 2, 5);
    send(3);
    check("hist_once", n_slice, 1);
    clear_counts();
    send(1);
    check("hist_repeat_blocked", n_slice, 0);
    clear_counts();
    for (int i = 10; i <= 12; i++) begin
      set_block(520, 360, 400, 1'b0, 1'b0, 2, i);
      send(1);
    end
    check("hist_others3", n_slice, 3);
    clear_counts();
    set_block(520, 360, 400, 1'b0, 1'b0, 2, 5);
    send(1);
    check("hist_still_held", n_slice, 0);
    clear_counts();
    set_block(520, 360, 400, 1'b0, 1'b0, 2, 13);
    send(1);
    set_block(520, 360, 400, 1'b0, 1'b0, 2, 5);
    send(1);
    check("hist_evicted", n_slice, 2);
    check("hist_evicted_id", block_ID_out, 5);

    // Both hands swing DOWN into a colour-1 block.
    clear_counts();
    set_left(500, 300, 500, 340);
    set_right(520, 300, 520, 340);
    set_block(520, 360, 400, 1'b1, 1'b0, 2, 30);
    send(1);
    check("color_slice", n_slice, 1);
    check("color_hand_right", last_hand, 1);
    check("either_single_pulse", n_slice_any, 1);
    check("either_left_wins", last_hand_any, 0);
    idle_hands();

    // Overlap near x=0 and at the +/-HIT_HALF edge.
    clear_counts();
    set_left(10, 300, 10, 340);
    set_block(20, 360, 400, 1'b0, 1'b0, 2, 40);
    send(1);
    check("ovl_low_x", n_slice, 1);
    clear_counts();
    set_block(111, 360, 400, 1'b0, 1'b0, 2, 41);
    send(1);
    check("ovl_101_out", n_slice, 0);
    clear_counts();
    set_block(110, 360, 400, 1'b0, 1'b0, 2, 42);
    send(1);
    check("ovl_100_in", n_slice, 1);
    idle_hands();

    // Obstacle at the head, same ID twice -> one hit.
    clear_counts();
    head_x = 12'd700; head_y = 12'd700;
    set_block(750, 650, 150, 1'b0, 1'b1, 4, 9);
    send(2);
    check("hit_once", n_hit, 1);
    check("hit_no_slice", n_slice, 0);
    check("hit_no_miss", n_miss, 0);
    head_x = 12'd2000; head_y = 12'd2000;

    // z==0 block nobody slices, same ID twice -> one miss.
    clear_counts();
    set_block(900, 900, 0, 1'b0, 1'b0, 2, 7);
    send(2);
    check("miss_once", n_miss, 1);
    check("miss_no_hit", n_hit, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
